// File: rtl/axi_ram_rd_arb.sv
// Two-requester read arbiter that issues one AXI INCR read burst at a time to a RAM slave.
// Define AXI_RAM_RD_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead of round-robin.
module axi_ram_rd_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s0_req_valid,
  input  logic [ADDR_WIDTH-1:0] s0_req_addr,
  input  logic [7:0]            s0_req_len,
  output logic                  s0_req_ready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic                  s0_rlast,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  input  logic                  s1_req_valid,
  input  logic [ADDR_WIDTH-1:0] s1_req_addr,
  input  logic [7:0]            s1_req_len,
  output logic                  s1_req_ready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic                  s1_rlast,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            count_q, count_d;
  logic                  gnt_q, gnt_d;
  logic                  lenErr_q, lenErr_d;
  logic                  gntSel;
  logic                  reqHs;
  logic                  rReadySel;
  logic                  rHs;

`ifndef AXI_RAM_RD_ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  // Winner among simultaneous requests; a lone requester always wins.
  always_comb begin
    gntSel = 1'b0;
    if (s0_req_valid && s1_req_valid) begin
`ifdef AXI_RAM_RD_ARB_FIXED_PRIO_EN
      gntSel = 1'b0;
`else
      gntSel = ~last_q;
`endif
    end else if (s1_req_valid) begin
      gntSel = 1'b1;
    end
  end

  assign reqHs     = (state_q == IDLE) && (s0_req_valid || s1_req_valid);
  assign rReadySel = gnt_q ? s1_rready : s0_rready;
  assign rHs       = (state_q == DATA) && m_axi_rvalid && rReadySel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (reqHs) state_d = ADDR;
      ADDR:    if (m_axi_arready) state_d = DATA;
      DATA:    if (rHs && m_axi_rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request ready is masked by reset so a held req_valid cannot be acknowledged while in reset.
  always_comb begin
    s0_req_ready  = reqHs && !gntSel && !rst;
    s1_req_ready  = reqHs && gntSel && !rst;
    m_axi_arvalid = (state_q == ADDR);
    m_axi_rready  = (state_q == DATA) && rReadySel;
    s0_rvalid     = (state_q == DATA) && !gnt_q && m_axi_rvalid;
    s1_rvalid     = (state_q == DATA) && gnt_q && m_axi_rvalid;
  end

  assign m_axi_arid    = ID_WIDTH'(gnt_q);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
  assign m_axi_arburst = 2'b01;
  assign s0_rdata      = m_axi_rdata;
  assign s1_rdata      = m_axi_rdata;
  assign s0_rlast      = m_axi_rlast;
  assign s1_rlast      = m_axi_rlast;
  assign len_err       = lenErr_q;

  // A length mismatch is flagged on either an early rlast or a missing one at the expected last beat.
  always_comb begin
    addr_d   = addr_q;
    len_d    = len_q;
    gnt_d    = gnt_q;
    count_d  = count_q;
    lenErr_d = 1'b0;
`ifndef AXI_RAM_RD_ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif
    if (reqHs) begin
      addr_d  = gntSel ? s1_req_addr : s0_req_addr;
      len_d   = gntSel ? s1_req_len : s0_req_len;
      gnt_d   = gntSel;
      count_d = 8'd0;
    end
    if (rHs) begin
      lenErr_d = (m_axi_rlast && (count_q != len_q)) || (!m_axi_rlast && (count_q == len_q));
      if (m_axi_rlast) begin
        count_d = 8'd0;
`ifndef AXI_RAM_RD_ARB_FIXED_PRIO_EN
        last_d  = gnt_q;
`endif
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
      len_q    <= 8'd0;
      gnt_q    <= 1'b0;
      count_q  <= 8'd0;
      lenErr_q <= 1'b0;
`ifndef AXI_RAM_RD_ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;
`endif
    end else begin
      addr_q   <= addr_d;
      len_q    <= len_d;
      gnt_q    <= gnt_d;
      count_q  <= count_d;
      lenErr_q <= lenErr_d;
`ifndef AXI_RAM_RD_ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

endmodule

// File: doc/axi_ram_rd_arb.md
AXI_RAM_RD_ARB -- requirements
Module: axi_ram_rd_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width (multiple of 8, power-of-two bytes).
REQ-002 SHALL have parameter ADDR_WIDTH, default 16, byte address width.
REQ-003 SHALL have parameter ID_WIDTH, default 8, AXI ID width, minimum 1.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have ports sN_req_valid, input, 1, requester N (N=0,1) burst request valid.
REQ-007 SHALL have ports sN_req_addr, input, ADDR_WIDTH, requester N start byte address.
REQ-008 SHALL have ports sN_req_len, input, 8, requester N beats minus one.
REQ-009 SHALL have ports sN_req_ready, output, 1, requester N request accepted.
REQ-010 SHALL have ports sN_rdata, output, DATA_WIDTH, requester N read data.
REQ-011 SHALL have ports sN_rlast, output, 1, requester N last beat.
REQ-012 SHALL have ports sN_rvalid, output, 1, requester N data valid.
REQ-013 SHALL have ports sN_rready, input, 1, requester N data ready.
REQ-014 SHALL have ports m_axi_arid/araddr/arlen, output, ID_WIDTH/ADDR_WIDTH/8, AXI read address fields to the RAM.
REQ-015 SHALL have ports m_axi_arsize/arburst, output, 3/2, constant log2(DATA_WIDTH/8) and INCR (2'b01).
REQ-016 SHALL have port m_axi_arvalid, output, 1, and m_axi_arready, input, 1, AR handshake.
REQ-017 SHALL have ports m_axi_rdata/rlast/rvalid, input, DATA_WIDTH/1/1, and m_axi_rready, output, 1, R channel.
REQ-018 SHALL have port len_err, output, 1, one-cycle pulse on burst-length mismatch.

Function
REQ-019 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE; one burst outstanding at a time.
REQ-020 IDLE: grant SHALL go to the single valid requester; if both are valid, to the port not granted last (round-robin pointer, initially favouring port 0).
REQ-021 IDLE: sN_req_ready SHALL be combinationally 1 only for the granted port; on valid&ready, latch addr, len and grant index, go to ADDR next cycle.
REQ-022 ADDR: m_axi_arvalid=1 with latched fields, arid = grant index zero-extended; fields stable until m_axi_arready; then go to DATA.
REQ-023 DATA: m_axi_rready SHALL equal sN_rready of granted port; granted sN_rvalid = m_axi_rvalid; other port rvalid=0; rdata/rlast passed combinationally to both ports.
REQ-024 DATA SHALL count accepted beats from 0; on handshake with m_axi_rlast=1 return to IDLE and set round-robin pointer to the granted port.
REQ-025 len_err SHALL pulse the cycle after a beat handshake where (rlast=1 and count!=len) or (count==len and rlast=0); in the latter case, keep forwarding until rlast.
REQ-026 Minimum request-to-request spacing: 3 cycles plus burst length; a request arriving while busy SHALL wait with req_ready=0.
REQ-027 Requester deasserting req_valid in IDLE before handshake SHALL cancel it with no AR issued.

Reset
REQ-028 While rst=1: state IDLE, m_axi_arvalid=0, m_axi_rready=0, sN_rvalid=0, sN_req_ready=0, len_err=0, pointer favours port 0, beat count 0.
REQ-029 Reset mid-burst SHALL abandon the burst immediately; the RAM's R stream is the integrator's responsibility.

Configuration
REQ-030 Macro AXI_RAM_RD_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests, pointer unused; undefined: round-robin per REQ-020.

Verification
REQ-031 s0 req addr=0x0010 len=3 alone -> araddr=0x0010, arlen=3, arid=0, 4 beats on s0, s0_rlast on 4th, s1_rvalid stays 0.
REQ-032 s0 and s1 valid same cycle, both len=0, repeat twice -> grant order 0,1,0,1 (with FIXED_PRIO_EN: 0,0 while s0 held).
REQ-033 m_axi_arready held 0 for 5 cycles -> arvalid held 1, araddr/arlen unchanged, no req_ready to either port.
REQ-034 s1_rready toggled every cycle during len=7 burst -> m_axi_rready mirrors it, 8 beats delivered in order, no loss.
REQ-035 RAM model asserts rlast on beat 2 of len=3 -> len_err pulses once, FSM returns to IDLE.
REQ-036 rst asserted during DATA beat 2 -> all outputs per REQ-028 same cycle, next request issues normally.
